param_gcd: RTL

PARAM_GCD -- requirements
Module: param_gcd

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_step.sv | 52 +++++
 rtl/param_gcd.sv | 101 ++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the parameterised GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic MODE_EUCLID = 1'b0;
  localparam logic MODE_STEIN  = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One combinational iteration of either Euclid subtraction or binary (Stein) GCD.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic [KW-1:0]    k,
  input  logic             rmode,
  output logic [WIDTH-1:0] ra_next,
  output logic [WIDTH-1:0] rb_next,
  output logic [KW-1:0]    k_next,
  output logic             term
);

  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;

  assign diff_ab = ra - rb;
  assign diff_ba = rb - ra;

  // Pick the next operand pair; a zero operand means the other one holds the odd part of the answer.
  always_comb begin
    ra_next = ra;
    rb_next = rb;
    k_next  = k;
    term    = (ra == '0) || (rb == '0);
    if (!term) begin
      if (rmode == MODE_EUCLID) begin
        if (ra >= rb) ra_next = diff_ab;
        else          rb_next = diff_ba;
      end else begin
        if (!ra[0] && !rb[0]) begin
          ra_next = ra >> 1;
          rb_next = rb >> 1;
          k_next  = k + KW'(1);
        end else if (!ra[0]) begin
          ra_next = ra >> 1;
        end else if (!rb[0]) begin
          rb_next = rb >> 1;
        end else if (ra >= rb) begin
          ra_next = diff_ab >> 1;
        end else begin
          rb_next = diff_ba >> 1;
        end
      end
    end
  end

endmodule

// File: rtl/param_gcd.sv
// Multi-cycle GCD engine: FSM plus operand, shift-count and iteration registers.
module param_gcd
  import gcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ITER_W = WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              ready,
  output logic              done,
  output logic [WIDTH-1:0]  gcd,
  output logic [ITER_W-1:0] iter
);

  localparam int KW = $clog2(WIDTH) + 1;

  state_t            state;
  logic [WIDTH-1:0]  ra;
  logic [WIDTH-1:0]  rb;
  logic [KW-1:0]     k;
  logic [ITER_W-1:0] counter;
  logic              rmode;

  logic [WIDTH-1:0]  ra_next;
  logic [WIDTH-1:0]  rb_next;
  logic [KW-1:0]     k_next;
  logic              term;

  gcd_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .ra      (ra),
    .rb      (rb),
    .k       (k),
    .rmode   (rmode),
    .ra_next (ra_next),
    .rb_next (rb_next),
    .k_next  (k_next),
    .term    (term)
  );

  // Control FSM; ready and done are registered so they track the state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      gcd     <= '0;
      iter    <= '0;
      ra      <= '0;
      rb      <= '0;
      k       <= '0;
      counter <= '0;
      rmode   <= MODE_EUCLID;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra      <= a;
            rb      <= b;
            rmode   <= mode;
            k       <= '0;
            counter <= '0;
            ready   <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          counter <= counter + ITER_W'(1);
          if (term) begin
            gcd   <= (ra | rb) << k;
            iter  <= counter + ITER_W'(1);
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            ra <= ra_next;
            rb <= rb_next;
            k  <= k_next;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
